p6502_busctl: RTL and testbench
===============================

# p6502_busctl

Parametrised CPU-cycle controller sitting between the `p6502` core wrapper and the arcade memory map. It derives `phi0`/`phi2` from the system clock with a configurable divide ratio. It stretches reads to one slow address region by holding RDY low for a programmable number of CPU cycles. It also captures a ring-buffer history of opcode-fetch addresses for debug, replacing ad-hoc simulation printing with a hardware-readable trace.

## Interface
Parameters:
- `DIV`, 4: clk cycles per CPU cycle; even, ≥2.
- `SLOW_BASE`, 16'h2000: base address of the slow region.
- `SLOW_MASK`, 16'hF000: match mask; a read is slow when `(cpu_a & SLOW_MASK) == SLOW_BASE`.
- `SLOW_WAIT`, 2: extra CPU cycles per slow read, 0..15.
- `TRACE_DEPTH`, 16: trace entries; power of two, ≥2.

Ports:
- `clk` in 1: system clock; single clock domain.
- `reset_n` in 1: reset, asynchronous, active-low.
- `cpu_a` in 16: CPU address bus.
- `cpu_rw_n` in 1: 1 = read.
- `cpu_sync` in 1: opcode-fetch cycle flag.
- `ext_rdy` in 1: external ready, ANDed into `cpu_rdy`.
- `phi0` out 1: CPU clock input.
- `phi2` out 1: equals `~phi0`.
- `cpu_rdy` out 1: RDY to the CPU.
- `cyc_strobe` out 1: one-clk pulse on the last clk of each CPU cycle.
- `trace_rd` in 1: pop the oldest trace entry.
- `trace_data` out 16: oldest entry, show-ahead; 0 when empty.
- `trace_count` out log2(TRACE_DEPTH)+1: number of entries held.
- `trace_ovf` out 1: sticky flag; an entry was overwritten.
- `pc_count` out 32: total captured fetches; wraps at 2^32.

## Operation
- Divider `div_cnt` counts 0..DIV-1 and wraps.
  - `phi0` = 0 for counts 0..DIV/2-1 and 1 for the rest. It is registered and glitch-free.
  - `cyc_strobe` = 1 when `div_cnt == DIV-1`.
- Wait-state FSM, states IDLE and WAIT, evaluated only on `cyc_strobe`:
  - IDLE → WAIT when all of these hold: `cpu_rw_n=1`, address matches the slow region, `SLOW_WAIT≠0`, `armed=1`. On this transition `wait_cnt` loads SLOW_WAIT−1 and `armed` clears.
  - WAIT: `wait_cnt` decrements each strobe. At 0 the FSM returns to IDLE.
  - `armed` sets on any strobe where `cpu_rdy=1` and the FSM stays in IDLE. This prevents the held address from re-triggering.
  - Writes never insert waits.
- `cpu_rdy` = `ext_rdy & (state==IDLE)`. It is combinational from the registered state and `ext_rdy`.
- Trace capture happens on a `cyc_strobe` where `cpu_sync=1` and `cpu_rdy=1`:
  - Write `cpu_a` at the write pointer.
  - Increment `pc_count`.
- Trace pop: a `trace_rd` pulse with `trace_count>0` advances the read pointer. A pop with `trace_count=0` is ignored.
- Full buffer with a capture and no pop: the oldest entry is overwritten, the read pointer advances, `trace_count` stays at DEPTH, and `trace_ovf` is set.
- Capture and pop in the same clk:
  - Pop is applied first, then write.
  - `trace_count` is unchanged, or becomes 1 if it was 0.
  - No overflow is flagged.
- Pointers wrap modulo TRACE_DEPTH. `trace_ovf` clears only on reset.

## Timing
- Reset values:
  - `div_cnt`=0, so `phi0`=0 and `phi2`=1.
  - `cyc_strobe`=0.
  - State IDLE, `armed`=1, so `cpu_rdy` follows `ext_rdy`.
  - Trace pointers and count 0, `trace_data`=0, `trace_ovf`=0, `pc_count`=0.
- Reset assertion mid-wait drops to IDLE immediately, asynchronously. The first strobe comes DIV clks after release.
- A slow read completes in SLOW_WAIT+1 CPU cycles, with `cpu_rdy` low for SLOW_WAIT strobes.
- `cpu_rdy` falls in the clk after the triggering strobe. It rises in the clk after the final WAIT strobe.
- Trace write and `pc_count` update: 1 clk after the capturing strobe.
- `trace_data` and `trace_count` reflect a pop 1 clk after `trace_rd`.

## Configuration
- `P6502_TRACE_EN` defined: the trace buffer and `pc_count` are built as described.
- Not defined:
  - No trace storage is synthesised.
  - `trace_data`, `trace_count` and `trace_ovf` are tied to 0 and `pc_count` is tied to 0.
  - `trace_rd` is ignored.
  - Clock and wait-state behaviour is identical in both builds.

## Test plan
- DIV=4, hold reset, release → `phi0` shows the pattern 0,0,1,1 repeating; `cyc_strobe` goes high every 4th clk; `phi2=~phi0`.
- Read from 16'h2010 with SLOW_WAIT=2 → `cpu_rdy` stays low for exactly 2 strobes, then goes high. The held address does not retrigger. A write to 16'h2010 produces no wait.
- Slow read with `ext_rdy` dropped during WAIT → `cpu_rdy` stays low until both conditions clear.
- Capture 20 syncs at addresses 16'hC000..16'hC013 with DEPTH=16 → `trace_count`=16, `trace_ovf`=1, `pc_count`=20. Successive pops return C004..C013, then `trace_data`=0 and the count is 0.
- Pop and capture in the same clk at count 16 → count stays 16 and `trace_ovf` does not newly set. A pop at count 0 is ignored.
- Assert `reset_n` low mid-WAIT and mid-trace → all outputs return to their reset values within the same clk. Build without `P6502_TRACE_EN` → trace outputs read 0 throughout.

Source files
------------

// File: rtl/p6502_busctl_if.sv
// p6502_busctl_if: CPU-side bus, derived clocks and trace read port of p6502_busctl.
interface p6502_busctl_if #(parameter int TRACE_DEPTH = 16);
    logic [15:0] cpu_a;
    logic cpu_rw_n, cpu_sync, ext_rdy, trace_rd;
    logic phi0, phi2, cpu_rdy, cyc_strobe, trace_ovf;
    logic [15:0] trace_data;
    logic [$clog2(TRACE_DEPTH):0] trace_count;
    logic [31:0] pc_count;
    modport master (
        output cpu_a, cpu_rw_n, cpu_sync, ext_rdy, trace_rd,
        input phi0, phi2, cpu_rdy, cyc_strobe, trace_data, trace_count, trace_ovf, pc_count
    );
    modport slave (
        input cpu_a, cpu_rw_n, cpu_sync, ext_rdy, trace_rd,
        output phi0, phi2, cpu_rdy, cyc_strobe, trace_data, trace_count, trace_ovf, pc_count
    );
endinterface

// File: rtl/p6502_busctl.sv
// p6502_busctl: phi0/phi2 divider, slow-region RDY wait states and opcode-fetch trace ring.
// Define P6502_TRACE_EN to build the trace buffer and pc_count; otherwise they read 0.
module p6502_busctl #(
    parameter int DIV = 4,
    parameter logic [15:0] SLOW_BASE = 16'h2000,
    parameter logic [15:0] SLOW_MASK = 16'hF000,
    parameter int SLOW_WAIT = 2,
    parameter int TRACE_DEPTH = 16
) (
    input logic clk,
    input logic reset_n,
    p6502_busctl_if.slave bus
);
    localparam int DW = $clog2(DIV);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;
    logic [DW-1:0] r_div_cnt, w_div_nxt;
    logic [0:0] r_state;
    logic [3:0] r_wait_cnt;
    logic r_phi0, r_armed, w_strobe, w_trig, w_rdy;
    assign w_strobe = r_div_cnt == DW'(DIV - 1);
    assign w_div_nxt = w_strobe ? '0 : r_div_cnt + 1'b1;
    assign w_rdy = bus.ext_rdy && r_state == S_IDLE;
    assign w_trig = bus.cpu_rw_n && (bus.cpu_a & SLOW_MASK) == SLOW_BASE && SLOW_WAIT != 0 && r_armed;
    assign bus.phi0 = r_phi0;
    assign bus.phi2 = ~r_phi0;
    assign bus.cyc_strobe = w_strobe;
    assign bus.cpu_rdy = w_rdy;
    // phi0 is registered from the next count so it is aligned with div_cnt and glitch-free
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
            r_phi0 <= 1'b0;
        end else begin
            r_div_cnt <= w_div_nxt;
            r_phi0 <= w_div_nxt >= DW'(DIV / 2);
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_armed <= 1'b1;
            r_wait_cnt <= '0;
        end else if (w_strobe) begin
            if (r_state == S_WAIT) begin
                r_state <= r_wait_cnt == '0 ? S_IDLE : S_WAIT;
                r_wait_cnt <= r_wait_cnt == '0 ? '0 : r_wait_cnt - 1'b1;
            end else if (w_trig) begin
                r_state <= S_WAIT;
                r_wait_cnt <= 4'(SLOW_WAIT - 1);
                r_armed <= 1'b0;
            end else if (w_rdy) begin
                r_armed <= 1'b1;
            end
        end
    end
`ifdef P6502_TRACE_EN
    localparam int AW = $clog2(TRACE_DEPTH);
    logic [15:0] r_mem [TRACE_DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0] r_cnt;
    logic [31:0] r_pc;
    logic r_ovf, w_cap, w_pop, w_full;
    assign w_cap = w_strobe && bus.cpu_sync && w_rdy;
    assign w_pop = bus.trace_rd && r_cnt != '0;
    assign w_full = r_cnt == (AW + 1)'(TRACE_DEPTH);
    assign bus.trace_data = r_cnt == '0 ? 16'h0000 : r_mem[r_rp];
    assign bus.trace_count = r_cnt;
    assign bus.trace_ovf = r_ovf;
    assign bus.pc_count = r_pc;
    always_ff @(posedge clk) begin
        if (w_cap) r_mem[r_wp] <= bus.cpu_a;
    end
    // a capture into a full buffer without a pop drops the oldest entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wp <= '0;
            r_rp <= '0;
            r_cnt <= '0;
            r_pc <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_cap) r_wp <= r_wp + 1'b1;
            if (w_cap) r_pc <= r_pc + 1'b1;
            if (w_pop || (w_cap && w_full)) r_rp <= r_rp + 1'b1;
            if (w_cap && !w_pop && w_full) r_ovf <= 1'b1;
            r_cnt <= (w_cap && !w_pop && !w_full) ? r_cnt + 1'b1 : (w_pop && !w_cap) ? r_cnt - 1'b1 : r_cnt;
        end
    end
`else
    assign bus.trace_data = '0;
    assign bus.trace_count = '0;
    assign bus.trace_ovf = 1'b0;
    assign bus.pc_count = '0;
`endif
endmodule

// File: tb/tb_p6502_busctl.sv
// tb_p6502_busctl: scoreboard bench for the divider, wait states and trace ring of p6502_busctl.
module tb_p6502_busctl;
    localparam int DIV = 4;
    localparam int SLOW_WAIT = 2;
    localparam int TD = 16;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int m = 0;
    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q[$];
    logic [1:0] clk_q[$];
    logic [31:0] exp_pc = 0;
    p6502_busctl_if #(.TRACE_DEPTH(TD)) bus();
    p6502_busctl #(.DIV(DIV), .SLOW_BASE(16'h2000), .SLOW_MASK(16'hF000), .SLOW_WAIT(SLOW_WAIT), .TRACE_DEPTH(TD)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave)
    );
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
    // m models the divider count the DUT should hold after each edge
    task automatic tick();
        @(posedge clk);
        m = reset_n ? (m + 1) % DIV : 0;
        #1;
    endtask
    task automatic to_strobe();
        while (m != DIV - 1) tick();
    endtask
    task automatic test_reset();
        bus.cpu_a = 16'h0000; bus.cpu_rw_n = 1'b1; bus.cpu_sync = 1'b0; bus.ext_rdy = 1'b1; bus.trace_rd = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.phi0 !== 1'b0) begin n_bad++; $display("FAIL reset_phi0 got %b want 0", bus.phi0); end
        n_cmp++; if (bus.phi2 !== 1'b1) begin n_bad++; $display("FAIL reset_phi2 got %b want 1", bus.phi2); end
        n_cmp++; if (bus.cyc_strobe !== 1'b0) begin n_bad++; $display("FAIL reset_strobe got %b want 0", bus.cyc_strobe); end
        n_cmp++; if (bus.cpu_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_rdy got %b want 1", bus.cpu_rdy); end
        n_cmp++; if (bus.trace_count !== '0) begin n_bad++; $display("FAIL reset_count got %0d want 0", bus.trace_count); end
        n_cmp++; if (bus.trace_data !== 16'h0) begin n_bad++; $display("FAIL reset_data got %h want 0000", bus.trace_data); end
        n_cmp++; if (bus.trace_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", bus.trace_ovf); end
        n_cmp++; if (bus.pc_count !== 32'h0) begin n_bad++; $display("FAIL reset_pc got %0d want 0", bus.pc_count); end
        bus.ext_rdy = 1'b0;
        #1;
        n_cmp++; if (bus.cpu_rdy !== 1'b0) begin n_bad++; $display("FAIL reset_rdy_follow got %b want 0", bus.cpu_rdy); end
        bus.ext_rdy = 1'b1;
        reset_n = 1'b1;
        m = 0;
    endtask
    task automatic test_clock();
        for (int i = 0; i < 3 * DIV; i++) begin
            tick();
            clk_q.push_back({m >= DIV / 2, m == DIV - 1});
            begin
                logic [1:0] e;
                e = clk_q.pop_front();
                n_cmp++; if (bus.phi0 !== e[1]) begin n_bad++; $display("FAIL clk_phi0[%0d] got %b want %b", i, bus.phi0, e[1]); end
                n_cmp++; if (bus.phi2 !== ~e[1]) begin n_bad++; $display("FAIL clk_phi2[%0d] got %b want %b", i, bus.phi2, ~e[1]); end
                n_cmp++; if (bus.cyc_strobe !== e[0]) begin n_bad++; $display("FAIL clk_strobe[%0d] got %b want %b", i, bus.cyc_strobe, e[0]); end
            end
        end
    endtask
    task automatic test_slow_read();
        int n;
        bus.cpu_a = 16'h2010; bus.cpu_rw_n = 1'b1;
        to_strobe();
        n_cmp++; if (bus.cpu_rdy !== 1'b1) begin n_bad++; $display("FAIL slow_pre got %b want 1", bus.cpu_rdy); end
        tick();
        n_cmp++; if (bus.cpu_rdy !== 1'b0) begin n_bad++; $display("FAIL slow_fall got %b want 0", bus.cpu_rdy); end
        n = 0;
        for (int k = 0; k < 8; k++) begin
            to_strobe();
            if (bus.cpu_rdy) break;
            n++;
            tick();
        end
        n_cmp++; if (n != SLOW_WAIT) begin n_bad++; $display("FAIL slow_wait_strobes got %0d want %0d", n, SLOW_WAIT); end
        tick();
        n_cmp++; if (bus.cpu_rdy !== 1'b1) begin n_bad++; $display("FAIL slow_no_retrigger got %b want 1", bus.cpu_rdy); end
        tick();
        n_cmp++; if (bus.cpu_rdy !== 1'b1) begin n_bad++; $display("FAIL slow_no_retrigger2 got %b want 1", bus.cpu_rdy); end
        bus.cpu_a = 16'h1000;
    endtask
    task automatic test_write();
        bus.cpu_a = 16'h2010; bus.cpu_rw_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            to_strobe();
            tick();
            n_cmp++; if (bus.cpu_rdy !== 1'b1) begin n_bad++; $display("FAIL write_no_wait[%0d] got %b want 1", k, bus.cpu_rdy); end
        end
        bus.cpu_rw_n = 1'b1; bus.cpu_a = 16'h1000;
    endtask
    task automatic test_ext_rdy();
        bus.cpu_a = 16'h2010;
        to_strobe();
        tick();
        n_cmp++; if (bus.cpu_rdy !== 1'b0) begin n_bad++; $display("FAIL ext_fall got %b want 0", bus.cpu_rdy); end
        bus.ext_rdy = 1'b0;
        repeat (SLOW_WAIT) begin to_strobe(); tick(); end
        n_cmp++; if (bus.cpu_rdy !== 1'b0) begin n_bad++; $display("FAIL ext_hold got %b want 0", bus.cpu_rdy); end
        to_strobe();
        tick();
        n_cmp++; if (bus.cpu_rdy !== 1'b0) begin n_bad++; $display("FAIL ext_hold2 got %b want 0", bus.cpu_rdy); end
        bus.cpu_a = 16'h1000; bus.ext_rdy = 1'b1;
        #1;
        n_cmp++; if (bus.cpu_rdy !== 1'b1) begin n_bad++; $display("FAIL ext_release got %b want 1", bus.cpu_rdy); end
        to_strobe();
        tick();
    endtask
    task automatic drain(input string tag);
        logic [15:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++; if (bus.trace_data !== e) begin n_bad++; $display("FAIL %s_pop got %h want %h", tag, bus.trace_data, e); end
            bus.trace_rd = 1'b1;
            tick();
            bus.trace_rd = 1'b0;
        end
        n_cmp++; if (bus.trace_count !== '0) begin n_bad++; $display("FAIL %s_empty_count got %0d want 0", tag, bus.trace_count); end
        n_cmp++; if (bus.trace_data !== 16'h0) begin n_bad++; $display("FAIL %s_empty_data got %h want 0000", tag, bus.trace_data); end
    endtask
    task automatic capture(input logic [15:0] a);
        bus.cpu_a = a; bus.cpu_sync = 1'b1;
        to_strobe();
        tick();
        exp_q.push_back(a);
        if (exp_q.size() > TD) void'(exp_q.pop_front());
        exp_pc++;
        bus.cpu_sync = 1'b0;
    endtask
`ifdef P6502_TRACE_EN
    task automatic test_trace_same_clk();
        bus.trace_rd = 1'b1;
        tick();
        bus.trace_rd = 1'b0;
        n_cmp++; if (bus.trace_count !== '0) begin n_bad++; $display("FAIL pop_empty_count got %0d want 0", bus.trace_count); end
        for (int i = 0; i < TD; i++) capture(16'hE000 + 16'(i));
        n_cmp++; if (bus.trace_count !== 5'(TD)) begin n_bad++; $display("FAIL same_full_count got %0d want %0d", bus.trace_count, TD); end
        n_cmp++; if (bus.trace_ovf !== 1'b0) begin n_bad++; $display("FAIL same_full_ovf got %b want 0", bus.trace_ovf); end
        bus.cpu_a = 16'hE010; bus.cpu_sync = 1'b1;
        to_strobe();
        bus.trace_rd = 1'b1;
        tick();
        bus.trace_rd = 1'b0; bus.cpu_sync = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(16'hE010);
        exp_pc++;
        n_cmp++; if (bus.trace_count !== 5'(TD)) begin n_bad++; $display("FAIL same_clk_count got %0d want %0d", bus.trace_count, TD); end
        n_cmp++; if (bus.trace_ovf !== 1'b0) begin n_bad++; $display("FAIL same_clk_ovf got %b want 0", bus.trace_ovf); end
        n_cmp++; if (bus.pc_count !== exp_pc) begin n_bad++; $display("FAIL same_clk_pc got %0d want %0d", bus.pc_count, exp_pc); end
        drain("same");
    endtask
    task automatic test_trace_overflow();
        for (int i = 0; i < 20; i++) capture(16'hC000 + 16'(i));
        n_cmp++; if (bus.trace_count !== 5'(TD)) begin n_bad++; $display("FAIL ovf_count got %0d want %0d", bus.trace_count, TD); end
        n_cmp++; if (bus.trace_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b want 1", bus.trace_ovf); end
        n_cmp++; if (bus.pc_count !== exp_pc) begin n_bad++; $display("FAIL ovf_pc got %0d want %0d", bus.pc_count, exp_pc); end
        drain("ovf");
    endtask
`else
    task automatic test_trace_off();
        for (int i = 0; i < 3; i++) begin
            bus.cpu_a = 16'hC000 + 16'(i); bus.cpu_sync = 1'b1;
            to_strobe();
            bus.trace_rd = 1'b1;
            tick();
            bus.trace_rd = 1'b0;
            n_cmp++; if (bus.trace_data !== 16'h0) begin n_bad++; $display("FAIL off_data got %h want 0000", bus.trace_data); end
            n_cmp++; if (bus.trace_count !== '0) begin n_bad++; $display("FAIL off_count got %0d want 0", bus.trace_count); end
            n_cmp++; if (bus.trace_ovf !== 1'b0) begin n_bad++; $display("FAIL off_ovf got %b want 0", bus.trace_ovf); end
            n_cmp++; if (bus.pc_count !== 32'h0) begin n_bad++; $display("FAIL off_pc got %0d want 0", bus.pc_count); end
        end
        bus.cpu_sync = 1'b0;
    endtask
`endif
    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) capture(16'hC100 + 16'(i));
        bus.cpu_a = 16'h2010; bus.cpu_rw_n = 1'b1;
        to_strobe();
        tick();
        tick();
        tick();
        n_cmp++; if (bus.cpu_rdy !== 1'b0) begin n_bad++; $display("FAIL rst_pre_wait got %b want 0", bus.cpu_rdy); end
        #2;
        reset_n = 1'b0;
        m = 0;
        exp_q.delete();
        exp_pc = 0;
        #1;
        n_cmp++; if (bus.cpu_rdy !== 1'b1) begin n_bad++; $display("FAIL rst_rdy got %b want 1", bus.cpu_rdy); end
        n_cmp++; if (bus.phi0 !== 1'b0) begin n_bad++; $display("FAIL rst_phi0 got %b want 0", bus.phi0); end
        n_cmp++; if (bus.phi2 !== 1'b1) begin n_bad++; $display("FAIL rst_phi2 got %b want 1", bus.phi2); end
        n_cmp++; if (bus.cyc_strobe !== 1'b0) begin n_bad++; $display("FAIL rst_strobe got %b want 0", bus.cyc_strobe); end
        n_cmp++; if (bus.trace_count !== '0) begin n_bad++; $display("FAIL rst_count got %0d want 0", bus.trace_count); end
        n_cmp++; if (bus.trace_data !== 16'h0) begin n_bad++; $display("FAIL rst_data got %h want 0000", bus.trace_data); end
        n_cmp++; if (bus.trace_ovf !== 1'b0) begin n_bad++; $display("FAIL rst_ovf got %b want 0", bus.trace_ovf); end
        n_cmp++; if (bus.pc_count !== exp_pc) begin n_bad++; $display("FAIL rst_pc got %0d want 0", bus.pc_count); end
        bus.cpu_a = 16'h1000;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= DIV; k++) begin
            tick();
            n_cmp++; if (bus.cyc_strobe !== (k == DIV - 1)) begin n_bad++; $display("FAIL rst_first_strobe[%0d] got %b want %b", k, bus.cyc_strobe, k == DIV - 1); end
        end
    endtask
    initial begin
        test_reset();
        test_clock();
        test_slow_read();
        test_write();
        test_ext_rdy();
`ifdef P6502_TRACE_EN
        test_trace_same_clk();
        test_trace_overflow();
`else
        test_trace_off();
`endif
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
